// File: rtl/stopwatch_mux_core.sv
// stopwatch_mux_core: BCD stopwatch with debounced buttons, lap freeze and a multiplexed 7-segment scan
//   clk_in          system clock, the only clock domain
//   reset           asynchronous active-low reset
//   start_stop_btn  raw button; each accepted press toggles running
//   lap_btn         raw button; freezes or releases the displayed value
//   clear           synchronous clear of count, run state, overflow and lap hold
//   seg             active-high segments a..g for the selected digit
//   digit_en        one-hot active-high digit select
//   count_bcd       live BCD count, digit i at [4i+3:4i]
//   running         high while counting
//   overflow        sticky flag set when the count wraps past its maximum
module stopwatch_mux_core #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 10,
    parameter int NUM_DIGITS      = 4,
    parameter int SEXAGESIMAL     = 1,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int SCAN_HZ         = 1000
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    start_stop_btn,
    input  logic                    lap_btn,
    input  logic                    clear,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    running,
    output logic                    overflow
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_MAX = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [IW-1:0] I_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0: decode = 7'h3F;
            4'd1: decode = 7'h06;
            4'd2: decode = 7'h5B;
            4'd3: decode = 7'h4F;
            4'd4: decode = 7'h66;
            4'd5: decode = 7'h6D;
            4'd6: decode = 7'h7D;
            4'd7: decode = 7'h07;
            4'd8: decode = 7'h7F;
            4'd9: decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    // bit 0 = start/stop, bit 1 = lap
    logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d, level_q, level_d, prev_q, prev_d, press;
    logic [1:0][DW-1:0]  dbc_q, dbc_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [CW-1:0]       count_q, count_d, lap_q, lap_d, disp;
    logic                running_q, running_d, overflow_q, overflow_d, hold_q, hold_d, tick, carry;
    logic [SW-1:0]       scan_q, scan_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic [6:0]          seg_q, seg_d;

    // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        sync1_d = {lap_btn, start_stop_btn};
        sync2_d = sync1_q;
        prev_d  = level_q;
        level_d = level_q;
        dbc_d   = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != level_q[b]) begin
                dbc_d[b]   = (dbc_q[b] == DB_MAX) ? '0 : dbc_q[b] + 1'b1;
                level_d[b] = (dbc_q[b] == DB_MAX) ? ~level_q[b] : level_q[b];
            end
        end
    end

    assign press = level_q & ~prev_q;

    always_comb begin
        tick    = running_q && (presc_q == P_MAX);
        carry   = tick;
        count_d = count_q;
        // Ripple increment; carry left set after the top digit means every digit wrapped
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == ((SEXAGESIMAL != 0 && i == 2) ? 4'd5 : 4'd9)) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        presc_d    = running_q ? (tick ? '0 : presc_q + 1'b1) : presc_q;
        overflow_d = overflow_q | carry;
        running_d  = running_q ^ press[0];
        hold_d     = hold_q;
        lap_d      = lap_q;
        // The latched lap value includes a tick landing in the same cycle
        if (press[1] && hold_q) begin
            hold_d = 1'b0;
        end else if (press[1] && running_q) begin
            hold_d = 1'b1;
            lap_d  = count_d;
        end
        if (clear) begin
            running_d  = 1'b0;
            count_d    = '0;
            presc_d    = '0;
            overflow_d = 1'b0;
            hold_d     = 1'b0;
        end
    end

    // Scan outputs are computed from next-state values so enable and segments switch together
    always_comb begin
        disp       = hold_d ? lap_d : count_d;
        scan_d     = (scan_q == S_MAX) ? '0 : scan_q + 1'b1;
        idx_d      = (scan_q != S_MAX) ? idx_q : (idx_q == I_MAX) ? '0 : idx_q + 1'b1;
        digit_en_d = ONE << idx_d;
        seg_d      = decode(disp[{idx_d, 2'b00} +: 4]);
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            prev_q     <= '0;
            dbc_q      <= '0;
            presc_q    <= '0;
            count_q    <= '0;
            lap_q      <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
            hold_q     <= 1'b0;
            scan_q     <= '0;
            idx_q      <= '0;
            digit_en_q <= ONE;
            seg_q      <= 7'h3F;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            prev_q     <= prev_d;
            dbc_q      <= dbc_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            lap_q      <= lap_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
            hold_q     <= hold_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            digit_en_q <= digit_en_d;
            seg_q      <= seg_d;
        end
    end

    assign seg       = seg_q;
    assign digit_en  = digit_en_q;
    assign count_bcd = count_q;
    assign running   = running_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_stopwatch_mux_core.sv
// tb_stopwatch_mux_core: self-checking bench with an arithmetic time model for stopwatch_mux_core
module tb_stopwatch_mux_core;
    logic clk = 0, rst_n = 0, ss = 0, lp = 0, clr = 0;
    logic [6:0]  seg;
    logic [3:0]  den;
    logic [15:0] cnt;
    logic        run, ovf;

    always #5 clk = ~clk;

    stopwatch_mux_core #(
        .CLK_HZ(1000), .TICK_HZ(100), .NUM_DIGITS(4), .SEXAGESIMAL(1),
        .DEBOUNCE_CYCLES(4), .SCAN_HZ(250)
    ) dut (
        .clk_in(clk), .reset(rst_n), .start_stop_btn(ss), .lap_btn(lp), .clear(clr),
        .seg(seg), .digit_en(den), .count_bcd(cnt), .running(run), .overflow(ovf)
    );

    int ncmp = 0, nfail = 0;
    logic [6:0] dec [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model: time is a number of tenths; digits derive from it by division
    bit m_run, m_ovf, m_hold;
    int m_ticks, m_total, m_pre, m_lap, m_n;
    bit s1 [2], s2 [2], lvl [2], pend [2];
    int dbc [2];

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 600 % 10), 4'(v / 100 % 6), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg();
        logic [15:0] d;
        int idx;
        d   = bcd(m_hold ? m_lap : m_ticks);
        idx = (m_n / 4) % 4;
        return dec[d[4*idx +: 4]];
    endfunction

    task automatic model_zero();
        m_run = 0; m_ovf = 0; m_hold = 0; m_ticks = 0; m_total = 0; m_pre = 0; m_lap = 0; m_n = 0;
        for (int b = 0; b < 2; b++) begin
            s1[b] = 0; s2[b] = 0; lvl[b] = 0; pend[b] = 0; dbc[b] = 0;
        end
    endtask

    task automatic model_edge();
        bit raw [2];
        bit ps, pl, tk, run_old;
        raw[0] = ss; raw[1] = lp;
        ps = pend[0]; pl = pend[1];
        for (int b = 0; b < 2; b++) begin
            pend[b] = 0;
            if (s2[b] != lvl[b]) begin
                dbc[b]++;
                if (dbc[b] == 4) begin
                    lvl[b]  = ~lvl[b];
                    dbc[b]  = 0;
                    pend[b] = lvl[b];
                end
            end else dbc[b] = 0;
            s2[b] = s1[b];
            s1[b] = raw[b];
        end
        m_n++;
        run_old = m_run;
        tk = m_run && m_pre == 9;
        if (clr) begin
            m_run = 0; m_ticks = 0; m_total = 0; m_pre = 0; m_ovf = 0; m_hold = 0;
        end else begin
            if (m_run) m_pre = tk ? 0 : m_pre + 1;
            if (tk) begin
                m_ticks++; m_total++;
                if (m_ticks == 6000) begin m_ticks = 0; m_ovf = 1; end
            end
            if (ps) m_run = !m_run;
            if (pl) begin
                if (m_hold) m_hold = 0;
                else if (run_old) begin m_hold = 1; m_lap = m_ticks; end
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic check_all();
        check("count_bcd", 32'(cnt), 32'(bcd(m_ticks)));
        check("running", 32'(run), 32'(m_run));
        check("overflow", 32'(ovf), 32'(m_ovf));
        check("digit_en", 32'(den), 32'(1) << ((m_n / 4) % 4));
        check("seg", 32'(seg), 32'(exp_seg()));
    endtask

    task automatic step(input bit chk);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (chk) check_all();
    endtask

    task automatic press_ss();
        ss = 1; repeat (8) step(1);
        ss = 0; repeat (8) step(1);
    endtask

    task automatic press_lap();
        lp = 1; repeat (8) step(1);
        lp = 0; repeat (8) step(1);
    endtask

    task automatic wait_pre(input int ticks, input int pre);
        int g = 0;
        while (!(m_run && (ticks < 0 || m_ticks == ticks) && m_pre == pre) && g < 20000) begin
            step(1); g++;
        end
        check("wait_bound", 32'(g < 20000), 32'd1);
    endtask

    typedef struct {
        int          ticks;
        logic [15:0] cnt;
        logic        ovf;
    } vec_t;
    vec_t tab [12];

    initial begin
        logic [15:0] fz;
        int c0, g;
        tab[0]  = '{1,    16'h0001, 1'b0};
        tab[1]  = '{9,    16'h0009, 1'b0};
        tab[2]  = '{10,   16'h0010, 1'b0};
        tab[3]  = '{59,   16'h0059, 1'b0};
        tab[4]  = '{60,   16'h0060, 1'b0};
        tab[5]  = '{99,   16'h0099, 1'b0};
        tab[6]  = '{100,  16'h0100, 1'b0};
        tab[7]  = '{599,  16'h0599, 1'b0};
        tab[8]  = '{600,  16'h1000, 1'b0};
        tab[9]  = '{5999, 16'h9599, 1'b0};
        tab[10] = '{6000, 16'h0000, 1'b1};
        tab[11] = '{6020, 16'h0020, 1'b1};

        model_zero();
        repeat (2) @(negedge clk);
        check("reset_seg", 32'(seg), 32'h3F);
        check("reset_digit_en", 32'(den), 32'h1);
        rst_n = 1;
        check_all();

        // short glitch is rejected; a long press starts after 2+4+1 cycles
        ss = 1; repeat (3) step(1);
        ss = 0; repeat (10) step(1);
        check("glitch_running", 32'(run), 32'd0);
        ss = 1; repeat (6) step(1);
        check("debounce_early", 32'(run), 32'd0);
        step(1);
        check("debounce_latency", 32'(run), 32'd1);
        step(1);
        ss = 0; repeat (12) step(1);
        check("release_no_toggle", 32'(run), 32'd1);

        clr = 1; step(1); clr = 0;
        check("clear_running", 32'(run), 32'd0);
        check("clear_count", 32'(cnt), 32'd0);

        // counting and radix table
        press_ss();
        for (int i = 0; i < 12; i++) begin
            g = 0;
            while (m_total < tab[i].ticks && g < 70000) begin step(0); g++; end
            check($sformatf("table_count_%0d", tab[i].ticks), 32'(cnt), 32'(tab[i].cnt));
            check($sformatf("table_ovf_%0d", tab[i].ticks), 32'(ovf), 32'(tab[i].ovf));
        end
        check_all();
        clr = 1; step(1); clr = 0;
        check("ovf_cleared", 32'(ovf), 32'd0);
        check("ovf_clear_running", 32'(run), 32'd0);
        check("ovf_clear_count", 32'(cnt), 32'd0);

        // lap freeze at 0042, then release, then ignored press while stopped
        press_ss();
        wait_pre(41, 3);
        lp = 1; repeat (8) step(1); lp = 0;
        fz = 16'h0042;
        for (int k = 0; k < 200; k++) begin
            step(1);
            check("lap_frozen_seg", 32'(seg), 32'(dec[fz[4*((m_n / 4) % 4) +: 4]]));
        end
        check("lap_live_advanced", 32'(cnt > 16'h0060), 32'd1);
        press_lap();
        press_ss();
        press_lap();
        check("lap_ignored_stopped", 32'(seg), 32'(exp_seg()));

        // pause keeps the partial tick
        press_ss();
        wait_pre(-1, 0);
        ss = 1; repeat (7) step(1);
        check("pause_stopped", 32'(run), 32'd0);
        repeat (3) step(1);
        ss = 0; repeat (40) step(1);
        c0 = m_ticks;
        ss = 1; repeat (7) step(1);
        check("restart_running", 32'(run), 32'd1);
        repeat (2) step(1);
        check("restart_no_tick", 32'(cnt), 32'(bcd(c0)));
        step(1);
        check("restart_tick", 32'(cnt), 32'(bcd(c0 + 1)));
        repeat (2) step(1);
        ss = 0; repeat (10) step(1);

        // clear wins over a simultaneous start/stop press
        press_ss();
        ss = 1; repeat (6) step(1);
        clr = 1; step(1); clr = 0;
        check("clear_prio_running", 32'(run), 32'd0);
        check("clear_prio_count", 32'(cnt), 32'd0);
        repeat (3) step(1);
        ss = 0; repeat (10) step(1);
        check("clear_prio_stays", 32'(run), 32'd0);

        // random buttons and clears against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 11) == 0) ss = ~ss;
            if ($urandom_range(0, 13) == 0) lp = ~lp;
            clr = ($urandom_range(0, 399) == 0);
            step(1);
        end
        ss = 0; lp = 0; clr = 0;

        // asynchronous reset mid-run
        press_ss();
        repeat (37) step(1);
        #2 rst_n = 0;
        #1 model_zero();
        check_all();
        @(negedge clk);
        check("reset_hold_seg", 32'(seg), 32'h3F);
        rst_n = 1;
        repeat (20) step(1);
        press_ss();
        repeat (30) step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
